// File: rtl/alu_muldiv_seq.sv
// Iterative RV32M/RV64M multiply/divide unit: shift-add multiply, restoring divide, one bit per clock.
// Latency: WORD_LENGTH+1 clocks from accept to out_valid; divide-by-zero and signed overflow take 1 clock.
// Backpressure: in_ready only in IDLE; the result is held in DONE until out_ready, with no bypass to a new op.
module alu_muldiv_seq #(
  parameter int WORD_LENGTH = 32,
  parameter int CNT_W       = 6
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2:0]             op_sel,
  input  logic [WORD_LENGTH-1:0] in_1,
  input  logic [WORD_LENGTH-1:0] in_2,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WORD_LENGTH-1:0] alu_out,
  output logic                   zero,
  output logic                   sign
);

  localparam int W = WORD_LENGTH;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WORD_LENGTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [W-1:0]     MOST_NEG = {1'b1, {(W-1){1'b0}}};

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t state, state_nxt;

  // Latched operation context.
  logic [2:0]       op_q;
  logic             neg_q;      // final result must be negated
  logic             special_q;  // result precomputed at accept, held in acc low half
  logic [CNT_W-1:0] cnt;
  logic [W-1:0]     addend;     // |multiplicand| for multiply, |divisor| for divide
  logic [2*W-1:0]   acc;        // multiply: {partial product, multiplier}; divide: low half is dividend/quotient
  logic [W-1:0]     rem_q;      // divide partial remainder (always < divisor)

  // Accept-time decode.
  logic         a_signed, b_signed, a_neg, b_neg, res_neg;
  logic         div_zero, div_ovf, special;
  logic [W-1:0] a_mag, b_mag, special_val;

  // Iteration datapath.
  logic [W:0]   mul_sum;
  logic [W:0]   div_trial;
  logic         div_ge;
  logic [W-1:0] div_diff;

  // Result selection.
  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   quo_fix, rem_fix, result;

  // Decode operand signedness, magnitudes, result sign and the short-cut cases from the incoming op.
  always_comb begin
    a_signed = (op_sel == OP_MULH) | (op_sel == OP_MULHSU) | (op_sel == OP_DIV) | (op_sel == OP_REM);
    b_signed = (op_sel == OP_MULH) | (op_sel == OP_DIV) | (op_sel == OP_REM);
    a_neg    = a_signed & in_1[W-1];
    b_neg    = b_signed & in_2[W-1];
    a_mag    = a_neg ? -in_1 : in_1;
    b_mag    = b_neg ? -in_2 : in_2;
    // A remainder follows the dividend; products and quotients follow the sign product.
    res_neg  = (op_sel == OP_REM) ? a_neg : (a_neg ^ b_neg);
    div_zero = op_sel[2] & (in_2 == '0);
    div_ovf  = ((op_sel == OP_DIV) | (op_sel == OP_REM)) & (in_1 == MOST_NEG) & (in_2 == '1);
    special  = div_zero | div_ovf;
    // op_sel[1] separates remainders (REM/REMU) from quotients (DIV/DIVU).
    if (div_zero) special_val = op_sel[1] ? in_1 : '1;
    else          special_val = op_sel[1] ? '0 : in_1;
  end

  // One shift-add step and one restoring-divide step, both evaluated from the current registers.
  always_comb begin
    mul_sum   = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, addend} : '0);
    div_trial = {rem_q, acc[W-1]};
    div_ge    = div_trial >= {1'b0, addend};
    // When div_ge holds the true difference is below the divisor, so W bits are exact.
    div_diff  = div_trial[W-1:0] - addend;
  end

  // Apply sign correction and pick the half/quantity the op asks for.
  always_comb begin
    prod_fix = neg_q ? -acc : acc;
    quo_fix  = neg_q ? -(acc[W-1:0]) : acc[W-1:0];
    rem_fix  = neg_q ? -rem_q : rem_q;
    result   = '0;
    if (special_q) begin
      result = acc[W-1:0];
    end else begin
      case (op_q)
        OP_MUL:                      result = prod_fix[W-1:0];
        OP_MULH, OP_MULHSU, OP_MULHU: result = prod_fix[2*W-1:W];
        OP_DIV, OP_DIVU:             result = quo_fix;
        OP_REM, OP_REMU:             result = rem_fix;
        default:                     result = '0;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state and handshake outputs.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = special ? FIX : CALC;
      end
      CALC: begin
        if (cnt == CNT_ONE) state_nxt = FIX;
      end
      FIX: begin
        state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, iteration and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q      <= '0;
      neg_q     <= 1'b0;
      special_q <= 1'b0;
      cnt       <= '0;
      addend    <= '0;
      acc       <= '0;
      rem_q     <= '0;
      alu_out   <= '0;
      zero      <= 1'b1;
      sign      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_q      <= op_sel;
            neg_q     <= res_neg;
            special_q <= special;
            cnt       <= CNT_INIT;
            rem_q     <= '0;
            if (special) begin
              addend <= '0;
              acc    <= {{W{1'b0}}, special_val};
            end else if (op_sel[2]) begin
              addend <= b_mag;
              acc    <= {{W{1'b0}}, a_mag};
            end else begin
              addend <= a_mag;
              acc    <= {{W{1'b0}}, b_mag};
            end
          end
        end
        CALC: begin
          cnt <= cnt - CNT_ONE;
          if (op_q[2]) begin
            rem_q        <= div_ge ? div_diff : div_trial[W-1:0];
            acc[W-1:0]   <= {acc[W-2:0], div_ge};
          end else begin
            acc <= {mul_sum, acc[W-1:1]};
          end
        end
        FIX: begin
          alu_out <= result;
          zero    <= (result == '0);
          sign    <= result[W-1];
        end
        default: ;
      endcase
    end
  end

endmodule
